// File: rtl/alu_exec_unit_if.sv
// Execute-stage handshake bundle: operands in (valid/ready), result and flags out (valid/ready).
// master = upstream mux and downstream consumer side, slave = the execute unit.
interface alu_exec_unit_if #(
    parameter int DWIDTH = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] instr;
    logic [DWIDTH:0]   operand_a;
    logic [DWIDTH:0]   operand_b;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] result;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;
    logic              flag_v;
    logic              flag_dz;
    logic              flag_ill;

    modport master (
        output in_valid, instr, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result,
        input  flag_z, flag_n, flag_c, flag_v, flag_dz, flag_ill
    );

    modport slave (
        input  in_valid, instr, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result,
        output flag_z, flag_n, flag_c, flag_v, flag_dz, flag_ill
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle ops valid 1 cycle after accept, DIV (restoring, 1 bit/cycle) after DWIDTH+1.
// One op in flight; the result is held until out_ready, and in_ready is low outside IDLE.
module alu_exec_unit #(
    parameter int DWIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int SHW     = $clog2(DWIDTH);
    localparam int CW      = $clog2(DWIDTH + 1);
    localparam int M       = DWIDTH - 1;
    localparam int OPC_MSB = (DWIDTH >= 32) ? 31 : DWIDTH - 1;

    localparam logic [4:0] OP_LW  = 5'd0;
    localparam logic [4:0] OP_SW  = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_MUL = 5'd5;
    localparam logic [4:0] OP_DIV = 5'd6;
    localparam logic [4:0] OP_AND = 5'd7;
    localparam logic [4:0] OP_OR  = 5'd8;
    localparam logic [4:0] OP_SHL = 5'd9;
    localparam logic [4:0] OP_SHR = 5'd10;
    localparam logic [4:0] OP_CMP = 5'd11;
    localparam logic [4:0] OP_NOT = 5'd12;

    typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic dz;
        logic ill;
    } flags_t;

    state_e            state_q;
    logic [DWIDTH-1:0] result_q;
    flags_t            flags_q;
    logic [DWIDTH-1:0] quot_q;
    logic [DWIDTH-1:0] rem_q;
    logic [DWIDTH-1:0] divisor_q;
    logic [CW-1:0]     cnt_q;

    logic [4:0]          opc;
    logic [DWIDTH-1:0]   a;
    logic [DWIDTH-1:0]   b;
    logic [SHW-1:0]      amt;
    logic [DWIDTH:0]     sum;
    logic [DWIDTH:0]     diff;
    logic [2*DWIDTH-1:0] prod;
    logic [DWIDTH:0]     shl_w;
    logic [DWIDTH:0]     shr_w;
    logic                add_ovf;
    logic                sub_ovf;
    logic                unused_ok;

    assign opc     = bus.instr[OPC_MSB -: 5];
    assign a       = bus.operand_a[M:0];
    assign b       = bus.operand_b[M:0];
    assign amt     = b[SHW-1:0];
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign prod    = {{DWIDTH{1'b0}}, a} * {{DWIDTH{1'b0}}, b};
    assign shl_w   = {1'b0, a} << amt;
    assign shr_w   = {a, 1'b0} >> amt;
    assign add_ovf = (a[M] == b[M]) && (sum[M] != a[M]);
    assign sub_ovf = (a[M] != b[M]) && (diff[M] != a[M]);
    assign unused_ok = ^{bus.instr, bus.operand_a[DWIDTH], bus.operand_b[DWIDTH]};

    logic [DWIDTH-1:0] res_d;
    flags_t            flags_d;

    always_comb begin
        res_d   = '0;
        flags_d = '0;
        case (opc)
            OP_LW, OP_SW, OP_ADD: begin
                res_d     = sum[M:0];
                flags_d.c = sum[DWIDTH];
                flags_d.v = add_ovf;
            end
            OP_SUB, OP_CMP: begin
                res_d     = (opc == OP_CMP) ? '0 : diff[M:0];
                flags_d.c = diff[DWIDTH];
                flags_d.v = sub_ovf;
            end
            OP_MUL: begin
                res_d     = prod[M:0];
                flags_d.c = |prod[2*DWIDTH-1:DWIDTH];
            end
            OP_DIV: begin
                // Only the divide-by-zero outcome is produced here; real divides iterate.
                res_d      = '1;
                flags_d.dz = 1'b1;
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_NOT: res_d = ~a;
            OP_SHL: begin
                res_d     = shl_w[M:0];
                flags_d.c = shl_w[DWIDTH];
            end
            OP_SHR: begin
                res_d     = shr_w[DWIDTH:1];
                flags_d.c = shr_w[0];
            end
            default: flags_d.ill = 1'b1;
        endcase
        flags_d.z = (res_d == '0);
        flags_d.n = res_d[M];
        if (opc == OP_CMP) begin
            flags_d.z = (diff[M:0] == '0);
            flags_d.n = diff[M];
        end
        if (flags_d.ill) begin
            flags_d.z = 1'b0;
            flags_d.n = 1'b0;
        end
    end

    logic [DWIDTH:0]   div_shift;
    logic [DWIDTH:0]   div_trial;
    logic              qbit;
    logic [DWIDTH-1:0] rem_nxt;
    logic [DWIDTH-1:0] quot_nxt;

    assign div_shift = {rem_q, quot_q[M]};
    assign div_trial = div_shift - {1'b0, divisor_q};
    assign qbit      = ~div_trial[DWIDTH];
    assign rem_nxt   = qbit ? div_trial[M:0] : div_shift[M:0];
    assign quot_nxt  = {quot_q[M-1:0], qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (opc == OP_DIV && b != '0) begin
                            state_q   <= DIV_RUN;
                            cnt_q     <= CW'(DWIDTH);
                            quot_q    <= a;
                            rem_q     <= '0;
                            divisor_q <= b;
                        end else begin
                            state_q  <= DONE;
                            result_q <= res_d;
                            flags_q  <= flags_d;
                        end
                    end
                end
                DIV_RUN: begin
                    quot_q <= quot_nxt;
                    rem_q  <= rem_nxt;
                    cnt_q  <= cnt_q - CW'(1);
                    // Final quotient bit lands on the same edge the counter hits zero.
                    if (cnt_q == CW'(1)) begin
                        state_q  <= DONE;
                        result_q <= quot_nxt;
                        flags_q  <= '{z: (quot_nxt == '0), n: quot_nxt[M],
                                      c: 1'b0, v: 1'b0, dz: 1'b0, ill: 1'b0};
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_n    = flags_q.n;
    assign bus.flag_c    = flags_q.c;
    assign bus.flag_v    = flags_q.v;
    assign bus.flag_dz   = flags_q.dz;
    assign bus.flag_ill  = flags_q.ill;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: hand-computed results, flags and latency per opcode.
module tb_alu_exec_unit;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.DWIDTH(DW)) bus ();

    alu_exec_unit #(.DWIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Flag vector order: {z, n, c, v, dz, ill}
    function automatic logic [5:0] flags();
        return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_dz, bus.flag_ill};
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [32:0] a, input logic [32:0] b,
                          output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.instr     = {op, 27'h0};
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.instr     = {5'd31, 27'h0};
        bus.operand_a = 33'($urandom);
        bus.operand_b = 33'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("drain_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic vec(input string tag, input logic [4:0] op, input logic [32:0] a,
                       input logic [32:0] b, input logic [31:0] exp_res,
                       input logic [5:0] exp_flags, input int exp_lat);
        int lat;
        run_op(op, a, b, lat);
        check({tag, "_lat"},   64'(lat),        64'(exp_lat));
        check({tag, "_res"},   64'(bus.result), 64'(exp_res));
        check({tag, "_flags"}, 64'(flags()),    64'(exp_flags));
        drain();
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.instr     = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        #12 rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_flags",     64'(flags()),       64'd0);

        vec("add_wrap",  5'd3,  33'hFFFFFFFF, 33'h1, 32'h0,        6'b101000, 1);
        vec("add_ovf",   5'd3,  33'h7FFFFFFF, 33'h1, 32'h80000000, 6'b010100, 1);
        vec("add_bit32", 5'd3,  33'h100000001, 33'h1, 32'h2,       6'b000000, 1);
        vec("lw",        5'd0,  33'd10, 33'd20, 32'd30,            6'b000000, 1);
        vec("sw",        5'd1,  33'd7,  33'd9,  32'd16,            6'b000000, 1);
        vec("sub_neg",   5'd4,  33'd3,  33'd5,  32'hFFFFFFFE,      6'b011000, 1);
        vec("sub_ovf",   5'd4,  33'h80000000, 33'h1, 32'h7FFFFFFF, 6'b000100, 1);
        vec("cmp_eq",    5'd11, 33'd5,  33'd5,  32'h0,             6'b100000, 1);
        vec("cmp_lt",    5'd11, 33'd3,  33'd5,  32'h0,             6'b011000, 1);
        vec("mul_hi",    5'd5,  33'h10000, 33'h10000, 32'h0,       6'b101000, 1);
        vec("mul_lo",    5'd5,  33'd1234, 33'd1000, 32'd1234000,   6'b000000, 1);
        vec("div_100_7", 5'd6,  33'd100, 33'd7, 32'd14,            6'b000000, 33);
        vec("div_max_1", 5'd6,  33'hFFFFFFFF, 33'h1, 32'hFFFFFFFF, 6'b010000, 33);
        vec("div_small", 5'd6,  33'd3, 33'd10, 32'd0,              6'b100000, 33);
        vec("div_zero",  5'd6,  33'd5, 33'd0, 32'hFFFFFFFF,        6'b010010, 1);
        vec("and",       5'd7,  33'hF0F0FF00, 33'h0FF0F0F0, 32'h00F0F000, 6'b000000, 1);
        vec("or",        5'd8,  33'hF0000000, 33'h0000000F, 32'hF000000F, 6'b010000, 1);
        vec("not",       5'd12, 33'hFFFFFFFF, 33'h12345678, 32'h0,  6'b100000, 1);
        vec("shl_c",     5'd9,  33'h80000001, 33'h1, 32'h00000002, 6'b001000, 1);
        vec("shl_mask",  5'd9,  33'h3, 33'h21, 32'h6,              6'b000000, 1);
        vec("shr_0",     5'd10, 33'h12345678, 33'h0, 32'h12345678, 6'b000000, 1);
        vec("shr_c",     5'd10, 33'h3, 33'h1, 32'h1,               6'b001000, 1);
        vec("ill_2",     5'd2,  33'd5, 33'd3, 32'h0,               6'b000001, 1);
        vec("ill_31",    5'd31, 33'd0, 33'd0, 32'h0,               6'b000001, 1);

        // Backpressure: result held, new request ignored while out_ready is low.
        run_op(5'd3, 33'h11, 33'h22, lat);
        check("bp_lat", 64'(lat), 64'd1);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.instr     = {5'd7, 27'h0};
        bus.operand_a = 33'h5;
        bus.operand_b = 33'h6;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_result",    64'(bus.result),    64'h33);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        drain();
        check("bp_not_taken", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a division.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.instr     = {5'd6, 27'h0};
        bus.operand_a = 33'd100;
        bus.operand_b = 33'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_result",    64'(bus.result),    64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_rst_flags",     64'(flags()),       64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("mid_rst_no_result", 64'(bus.out_valid), 64'd0);
        vec("add_after_rst", 5'd3, 33'd1, 33'd1, 32'd2, 6'b000000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
